// File: rtl/axis_pingpong_buffer.sv
// Two-bank ping-pong AXI-Stream frame buffer with a per-frame length and early s_last termination.
// Define AXB_LEN_CHECK_EN to build the sticky frame-length error flags. Otherwise err is tied to 0.
//
//   state   | meaning
//   W_IDLE  | wait for ex_start while the write bank is EMPTY
//   W_ACK   | ex_startAck high; frame length latched on entry
//   W_FILL  | accept beats into the write bank until len or s_last
//   R_IDLE  | wait for the read bank to become FULL
//   R_WAIT  | settle delay of WAITCYCLES cycles before draining
//   R_DRAIN | present bank[rcnt] on the master side until the last beat transfers
module axis_pingpong_buffer #(
   parameter int DATAWIDTH  = 32,
   parameter int DEPTH      = 8,
   parameter int WAITCYCLES = 5,
   parameter int LENWIDTH   = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ex_start,
   output logic                 ex_startAck,
   input  logic [LENWIDTH-1:0]  cfg_len,
   input  logic [DATAWIDTH-1:0] s_data,
   input  logic                 s_valid,
   input  logic                 s_last,
   output logic                 s_ready,
   output logic [DATAWIDTH-1:0] m_data,
   output logic                 m_valid,
   output logic                 m_last,
   input  logic                 m_ready,
   output logic [1:0]           frames_pending,
   output logic [1:0]           err
);

   localparam int AW = $clog2(DEPTH);
   localparam int WW = (WAITCYCLES > 1) ? $clog2(WAITCYCLES) : 1;
   localparam logic [LENWIDTH-1:0] LEN_MAX   = LENWIDTH'(DEPTH);
   localparam logic [LENWIDTH-1:0] LEN_ONE   = LENWIDTH'(1);
   localparam logic [WW-1:0]       WAIT_LOAD = WW'((WAITCYCLES > 0) ? WAITCYCLES - 1 : 0);

   typedef enum logic [1:0] {W_IDLE, W_ACK, W_FILL} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DRAIN} r_state_t;

   w_state_t w_state, w_next;
   r_state_t r_state, r_next;

   logic [DATAWIDTH-1:0] mem [2][DEPTH];
   logic [1:0]           bank_full;
   logic [LENWIDTH-1:0]  bank_len [2];
   logic                 wptr, rptr;
   logic [LENWIDTH-1:0]  wcnt, rcnt, len_q;
   logic [WW-1:0]        wait_cnt;
   logic                 len_load;
   logic                 w_last_beat, r_last_beat;
   logic                 fill_done, drain_done;

   assign w_last_beat = (wcnt == len_q - LEN_ONE);
   assign r_last_beat = (rcnt == bank_len[rptr] - LEN_ONE);
   assign fill_done   = (w_state == W_FILL) && s_valid && (w_last_beat || s_last);
   assign drain_done  = (r_state == R_DRAIN) && m_ready && r_last_beat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
      end else begin
         w_state <= w_next;
         r_state <= r_next;
      end
   end

   always_comb begin
      w_next      = w_state;
      ex_startAck = 1'b0;
      s_ready     = 1'b0;
      len_load    = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (ex_start && !bank_full[wptr]) begin
               w_next   = W_ACK;
               len_load = 1'b1;
            end
         end
         W_ACK: begin
            ex_startAck = 1'b1;
            if (!ex_start) w_next = W_FILL;
         end
         W_FILL: begin
            s_ready = 1'b1;
            if (fill_done) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   always_comb begin
      r_next  = r_state;
      m_valid = 1'b0;
      m_last  = 1'b0;
      m_data  = '0;
      case (r_state)
         R_IDLE: begin
            if (bank_full[rptr]) r_next = (WAITCYCLES == 0) ? R_DRAIN : R_WAIT;
         end
         R_WAIT: begin
            if (wait_cnt == '0) r_next = R_DRAIN;
         end
         R_DRAIN: begin
            m_valid = 1'b1;
            m_last  = r_last_beat;
            m_data  = mem[rptr][rcnt[AW-1:0]];
            if (drain_done) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   // Storage is deliberately not reset; only the bank flags say what is valid.
   always_ff @(posedge clk) begin
      if (w_state == W_FILL && s_valid) mem[wptr][wcnt[AW-1:0]] <= s_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr           <= 1'b0;
         rptr           <= 1'b0;
         wcnt           <= '0;
         rcnt           <= '0;
         len_q          <= LEN_MAX;
         wait_cnt       <= '0;
         bank_full      <= 2'b00;
         bank_len[0]    <= '0;
         bank_len[1]    <= '0;
         frames_pending <= 2'd0;
      end else begin
         if (len_load) len_q <= (cfg_len == '0 || cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

         if (w_state == W_FILL && s_valid) begin
            if (fill_done) begin
               wcnt            <= '0;
               wptr            <= ~wptr;
               bank_full[wptr] <= 1'b1;
               bank_len[wptr]  <= wcnt + LEN_ONE;
            end else begin
               wcnt <= wcnt + LEN_ONE;
            end
         end

         if (r_state == R_IDLE)
            wait_cnt <= WAIT_LOAD;
         else if (r_state == R_WAIT && wait_cnt != '0)
            wait_cnt <= wait_cnt - WW'(1);

         // Fill and drain always target different banks, so both may update bank_full together.
         if (drain_done) begin
            rcnt            <= '0;
            rptr            <= ~rptr;
            bank_full[rptr] <= 1'b0;
         end else if (r_state == R_DRAIN && m_ready) begin
            rcnt <= rcnt + LEN_ONE;
         end

         case ({fill_done, drain_done})
            2'b10:   frames_pending <= frames_pending + 2'd1;
            2'b01:   frames_pending <= frames_pending - 2'd1;
            default: frames_pending <= frames_pending;
         endcase
      end
   end

`ifdef AXB_LEN_CHECK_EN
   logic [1:0] err_q;
   logic       err_short, err_long;

   assign err_short = fill_done && s_last && !w_last_beat;
   assign err_long  = (w_state == W_FILL) && s_valid && w_last_beat && !s_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_q <= 2'b00;
      else if (len_load)
         err_q <= 2'b00;
      else
         err_q <= err_q | {err_long, err_short};
   end

   assign err = err_q;
`else
   assign err = 2'b00;
`endif

endmodule

// File: tb/tb_axis_pingpong_buffer.sv
// Bench for axis_pingpong_buffer: directed frames, checked against a beat-queue model every cycle.
module tb_axis_pingpong_buffer;

   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int LW    = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          ex_start;
   logic          ex_startAck;
   logic [LW-1:0] cfg_len;
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_last;
   logic          s_ready;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_last;
   logic          m_ready;
   logic [1:0]    frames_pending;
   logic [1:0]    err;

   int errors = 0;
   int checks = 0;

   // Model: every accepted slave beat, tagged with whether it ends its frame.
   logic [32:0] exp_q[$];
   logic [32:0] drained[$];
   int          model_pending;
   int          fill_cnt;
   int          cur_len;
   logic [1:0]  model_err;
   logic        prev_ack, prev_stall, prev_last;
   logic [31:0] prev_data;

   axis_pingpong_buffer dut (
      .clk            (clk),
      .rst            (rst),
      .ex_start       (ex_start),
      .ex_startAck    (ex_startAck),
      .cfg_len        (cfg_len),
      .s_data         (s_data),
      .s_valid        (s_valid),
      .s_last         (s_last),
      .s_ready        (s_ready),
      .m_data         (m_data),
      .m_valid        (m_valid),
      .m_last         (m_last),
      .m_ready        (m_ready),
      .frames_pending (frames_pending),
      .err            (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : monitor
      logic [32:0] e;
      int          fe, de;
      if (rst) begin
         exp_q.delete();
         model_pending = 0;
         fill_cnt      = 0;
         model_err     = 2'b00;
         prev_ack      = 1'b0;
         prev_stall    = 1'b0;
      end else begin
         fe = 0;
         de = 0;
         if (prev_stall) begin
            check("stall_valid", m_valid, 1'b1);
            check("stall_data", m_data, prev_data);
            check("stall_last", m_last, prev_last);
         end
         if (m_valid) check("valid_with_full_frame", model_pending > 0, 1'b1);
         if (m_valid && m_ready) begin
            check("queue_has_beat", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("m_data", m_data, e[31:0]);
               check("m_last", m_last, e[32]);
               drained.push_back({m_last, m_data});
               if (e[32]) de = 1;
            end
         end
         if (ex_startAck && !prev_ack) model_err = 2'b00;
         check("frames_pending", frames_pending, model_pending);
`ifdef AXB_LEN_CHECK_EN
         check("err", err, model_err);
`else
         check("err", err, 2'b00);
`endif
         if (s_valid && s_ready) begin
            fill_cnt++;
            if (fill_cnt == cur_len || s_last) begin
               if (s_last && fill_cnt < cur_len) model_err[0] = 1'b1;
               if (fill_cnt == cur_len && !s_last) model_err[1] = 1'b1;
               exp_q.push_back({1'b1, s_data});
               fill_cnt = 0;
               fe = 1;
            end else begin
               exp_q.push_back({1'b0, s_data});
            end
         end
         model_pending = model_pending + fe - de;
         prev_ack   = ex_startAck;
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
      end
   end

   task automatic start_frame(input int len);
      logic ok;
      ok       = 1'b0;
      cfg_len  = LW'(len);
      ex_start = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (ex_startAck) begin
            ok = 1'b1;
            break;
         end
      end
      check("ack_seen", ok, 1'b1);
      @(posedge clk);
      #1;
      ex_start = 1'b0;
      cur_len  = (len == 0 || len > DEPTH) ? DEPTH : len;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic l);
      logic ok;
      ok      = 1'b0;
      s_data  = d;
      s_valid = 1'b1;
      s_last  = l;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (s_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check("s_ready_seen", ok, 1'b1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_frame(input int len, input logic [31:0] base, input int n, input int last_idx);
      start_frame(len);
      for (int i = 0; i < n; i++) send_beat(base + 32'(i), i == last_idx);
   endtask

   task automatic wait_valid(output int k);
      k = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (m_valid) begin
            k = i;
            break;
         end
      end
      check("m_valid_seen", k > 0, 1'b1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ack"}, ex_startAck, 1'b0);
      check({tag, "_s_ready"}, s_ready, 1'b0);
      check({tag, "_m_valid"}, m_valid, 1'b0);
      check({tag, "_m_last"}, m_last, 1'b0);
      check({tag, "_m_data"}, m_data, 32'h0);
      check({tag, "_pending"}, frames_pending, 2'd0);
      check({tag, "_err"}, err, 2'b00);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int  k;
      logic seen;
      rst      = 1'b1;
      ex_start = 1'b0;
      cfg_len  = '0;
      s_data   = '0;
      s_valid  = 1'b0;
      s_last   = 1'b0;
      m_ready  = 1'b1;
      cur_len  = DEPTH;
      #1;
      check_idle_outputs("reset");
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Full frame of 8, s_last on the 8th beat.
      drained.delete();
      send_frame(8, 32'h10, 8, 7);
      wait_valid(k);
      check("t1_first_valid_latency", k, 7);
      check("t1_pending_in_drain", frames_pending, 2'd1);
      repeat (12) @(negedge clk);
      #1;
      check("t1_beats", drained.size(), 8);
      for (int i = 0; i < 8; i++)
         if (i < drained.size()) check("t1_beat", drained[i], {i == 7, 32'h10 + 32'(i)});
      check("t1_pending_end", frames_pending, 2'd0);

      // Early s_last on the 3rd beat.
      drained.delete();
      send_frame(8, 32'hA0, 3, 2);
      @(negedge clk);
`ifdef AXB_LEN_CHECK_EN
      check("t2_err_short", err, 2'b01);
`else
      check("t2_err_short", err, 2'b00);
`endif
      repeat (20) @(negedge clk);
      #1;
      check("t2_beats", drained.size(), 3);
      if (drained.size() == 3) begin
         check("t2_first", drained[0], {1'b0, 32'hA0});
         check("t2_last", drained[2], {1'b1, 32'hA2});
      end

      // Two frames with the master stalled, then a third start that must wait for bank 0.
      m_ready = 1'b0;
      drained.delete();
      send_frame(4, 32'h30, 4, 3);
      send_frame(4, 32'h40, 4, 3);
      @(negedge clk);
      check("t3_pending_two", frames_pending, 2'd2);
      cfg_len  = LW'(3);
      ex_start = 1'b1;
      seen     = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (ex_startAck) seen = 1'b1;
      end
      check("t3_no_ack_while_full", seen, 1'b0);
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      k = 0;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         if (ex_startAck) begin
            k = i;
            break;
         end
      end
      check("t3_ack_after_drain", k, 6);
      start_frame(3);
      for (int i = 0; i < 3; i++) send_beat(32'h60 + 32'(i), i == 2);
      repeat (30) @(negedge clk);
      #1;
      check("t3_beats", drained.size(), 11);
      if (drained.size() == 11) begin
         check("t3_a_first", drained[0], {1'b0, 32'h30});
         check("t3_a_last", drained[3], {1'b1, 32'h33});
         check("t3_b_first", drained[4], {1'b0, 32'h40});
         check("t3_c_last", drained[10], {1'b1, 32'h62});
      end

      // Drain with m_ready toggling.
      m_ready = 1'b0;
      drained.delete();
      send_frame(4, 32'h01, 4, 3);
      wait_valid(k);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         m_ready = (i % 2 == 0);
      end
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      check("t4_beats", drained.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < drained.size()) check("t4_beat", drained[i], {i == 3, 32'h01 + 32'(i)});

      // cfg_len=0 means DEPTH; frame ends on the 8th beat without s_last.
      drained.delete();
      send_frame(0, 32'h50, 8, -1);
      @(negedge clk);
      check("t5_s_ready_after_8", s_ready, 1'b0);
`ifdef AXB_LEN_CHECK_EN
      check("t5_err_long", err, 2'b10);
`else
      check("t5_err_long", err, 2'b00);
`endif
      repeat (20) @(negedge clk);
      #1;
      check("t5_beats", drained.size(), 8);
      if (drained.size() == 8) begin
         check("t5_beat6", drained[6], {1'b0, 32'h56});
         check("t5_beat7", drained[7], {1'b1, 32'h57});
      end

      // Reset in the middle of a fill.
      drained.delete();
      start_frame(8);
      for (int i = 0; i < 3; i++) send_beat(32'h70 + 32'(i), 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_idle_outputs("t6_in_reset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      check("t6_no_beats", drained.size(), 0);
      check("t6_pending", frames_pending, 2'd0);
      send_frame(2, 32'h80, 2, 1);
      repeat (20) @(negedge clk);
      #1;
      check("t6_recover_beats", drained.size(), 2);
      if (drained.size() == 2) check("t6_recover_last", drained[1], {1'b1, 32'h81});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axis_pingpong_buffer.md
Name: axis_pingpong_buffer

Overview:
Parametrised successor to the team's single-bank AXI-Stream frame buffer. Two memory banks operate ping-pong, so one frame fills from the slave side while the previous frame drains to the master side. The frame length is set per frame at run time, and frames terminate early on s_last. The block sits between the DMA stream and the CNN datapath, and keeps the ex_start/ex_startAck start handshake.

Parameters:
DATAWIDTH, 32, stream data width in bits
DEPTH, 8, maximum beats per frame (words per bank), >=2
WAITCYCLES, 5, idle cycles between a bank becoming full and its drain starting; 0 = drain next cycle
LENWIDTH, $clog2(DEPTH+1), width of cfg_len

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
ex_start  in  1  request to accept a new frame
ex_startAck  out  1  start acknowledge, held until ex_start drops
cfg_len  in  LENWIDTH  frame length in beats, sampled on the cycle ex_startAck first rises
s_data  in  DATAWIDTH  slave data
s_valid  in  1  slave valid
s_last  in  1  slave last; terminates the frame early
s_ready  out  1  slave ready
m_data  out  DATAWIDTH  master data
m_valid  out  1  master valid
m_last  out  1  final beat of the frame
m_ready  in  1  master ready
frames_pending  out  2  number of full banks not yet fully drained (0..2)
err  out  2  {err_long, err_short}; see Optional Feature

Behaviour:
- Reset (async, rst=1): all outputs 0, both banks marked EMPTY, counters 0, write/read bank pointers set to bank 0. Memory contents are not cleared. Any partial frame in fill or drain is discarded.
- Bank flags: each bank has a flag FULL/EMPTY plus a latched length len_b (1..DEPTH).
- Write FSM states:
  - W_IDLE: ex_start=1 and the write bank is EMPTY -> W_ACK. If the write bank is FULL, stay in W_IDLE with no ack.
  - W_ACK: ex_startAck=1. cfg_len is latched on entry; cfg_len=0 or cfg_len>DEPTH becomes DEPTH. ex_start=0 -> W_FILL.
  - W_FILL: s_ready=1. A beat is accepted when s_valid&s_ready and written to bank[wcnt], then wcnt increments. The frame ends on the accepted beat where wcnt==len-1 or s_last=1, whichever comes first. On frame end: len_b = beats accepted, the bank goes FULL, the write pointer toggles, wcnt clears, and the FSM returns to W_IDLE.
- Read FSM states:
  - R_IDLE: read bank FULL -> R_WAIT.
  - R_WAIT: the wait counter counts WAITCYCLES cycles, then -> R_DRAIN. With WAITCYCLES=0, go straight to R_DRAIN.
  - R_DRAIN: m_valid=1 and m_data=bank[rcnt] (combinational read). m_last=1 whenever rcnt==len_b-1; it is independent of m_ready. A beat is transferred on m_valid&m_ready, then rcnt increments. On the final transfer the bank goes EMPTY, the read pointer toggles, rcnt clears, and the FSM returns to R_IDLE.
- m_data, m_valid and m_last stay stable while m_valid=1 and m_ready=0.
- Same-cycle full/empty update: a bank the read side releases becomes EMPTY at the clock edge. The write side sees it the following cycle, so there is no same-cycle reuse. A bank the write side completes is visible to the read side the next cycle.
- frames_pending = number of FULL banks, registered. It increments at fill completion and decrements at drain completion. Both events in the same cycle leave it unchanged.
- Throughput: one beat per cycle on each side. Fill and drain run concurrently on different banks.

Optional Feature:
Macro AXB_LEN_CHECK_EN.
- Defined:
  - err_short pulses for 1 cycle when s_last ends a frame before len beats.
  - err_long pulses for 1 cycle when the len-th beat is accepted with s_last=0.
  - Both errors are sticky into a register, cleared by reset or by the next ex_startAck rise.
  - err outputs the sticky bits.
- Not defined: err is tied to 2'b00 and no check logic is built. Frame termination is identical in both builds.

Test Plan:
- cfg_len=8, 8 beats 0x10..0x17 with s_last on the 8th, m_ready=1 -> after 5 wait cycles, 8 contiguous m_valid beats 0x10..0x17, m_last only on 0x17, frames_pending 1->0.
- cfg_len=8, s_last on the 3rd beat (0xA0..0xA2) -> 3 beats drained, m_last on 0xA2. With AXB_LEN_CHECK_EN, err=2'b01.
- Two back-to-back frames of 4, m_ready=0 -> second ex_startAck is granted, frames_pending=2. Third ex_start gets no ack until m_ready=1 drains bank 0 and the bank's EMPTY flag has propagated.
- m_ready toggling 1,0,1,0 during drain of 0x01..0x04 -> each beat is held stable while stalled, and order is preserved.
- cfg_len=0 -> treated as DEPTH=8. Frame ends on the 8th beat even with s_last=0. With AXB_LEN_CHECK_EN, err=2'b10.
- rst pulsed mid-fill after 3 beats -> all outputs 0 the same cycle, frames_pending=0, no m_valid afterwards until a new frame completes.
